router_input_unit: RTL
======================

# router_input_unit

Per-input-port buffering and route computation stage of the mesh router. It sits directly upstream of the per-output-port arbiters. It stores incoming flits in a small FIFO, computes a dimension-ordered (XY) route from each head flit, and presents a one-hot route request that is held for the whole packet. It returns one credit upstream per flit consumed by the crossbar.

## Interface
Parameters:
- FLIT_W, 34, flit width; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, [FLIT_W-3 -: 3] = dest_x, [FLIT_W-6 -: 3] = dest_y (head flits only).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- LOCAL_X, 0, this router's X coordinate (3 bits).
- LOCAL_Y, 0, this router's Y coordinate (3 bits).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset; asynchronous, active-low.
- data_in  in  FLIT_W  incoming flit.
- data_in_valid  in  1  data_in is written this cycle.
- credit_out  out  1  one-cycle pulse per flit dequeued.
- forward  in  1  crossbar consumed the flit at flit_out this cycle.
- flit_out  out  FLIT_W  FIFO head flit; 0 when empty.
- valid_out  out  1  FIFO non-empty.
- route_req  out  5  one-hot target output: [0]=N, [1]=S, [2]=W, [3]=E, [4]=Local; 0 when empty.
- is_head / is_tail  out  1 each  flags of flit_out, gated by valid_out.
- overflow  out  1  sticky: a write arrived while the FIFO was full.
- protocol_err  out  1  sticky: the head/tail sequence was violated.

## Operation
- FIFO: circular buffer with read/write pointers of clog2(DEPTH) bits that wrap naturally. The count is clog2(DEPTH)+1 bits.
- Write: data_in_valid && count<DEPTH → store and increment. If count==DEPTH, the flit is dropped and overflow←1, even when forward fires in the same cycle.
- Read: forward && valid_out → pop and decrement. forward while empty is ignored.
- Credit protocol: upstream starts with DEPTH credits and decrements one per flit sent.
- XY routing, evaluated on the head flit:
  - dest_x>LOCAL_X → E; dest_x<LOCAL_X → W.
  - else dest_y<LOCAL_Y → N; dest_y>LOCAL_Y → S.
  - else Local.
  - Comparisons are unsigned, 3 bits.
- FSM states: IDLE (expecting a head) and BODY (packet in progress). route_q is a 5-bit register.
  - IDLE, head at flit_out: route_req = XY(flit_out).
    - On forward with tail=0: route_q←route, go to BODY.
    - On forward with tail=1 (single-flit packet): stay in IDLE.
  - IDLE, non-head at flit_out: protocol_err←1. The flit is auto-popped without forward, a credit is returned, and route_req=0.
  - BODY: route_req = route_q for every flit.
    - On forward of a tail: go to IDLE and set route_q←0.
    - A head-flagged flit in BODY sets protocol_err←1 and is forwarded as a body flit using route_q.
  - BODY with an empty FIFO (bubble): route_req=0. The packet state and route_q are retained, and the downstream grant lock is unaffected.
- route_req is therefore constant from the head to the tail of a packet whenever flits are present.

## Timing
- Reset (rst low, asynchronous) clears the pointers, count, FSM (→IDLE), route_q, credit_out, overflow and protocol_err. All outputs read 0 while in reset.
- Write-to-visible latency is 1 cycle; there is no bypass. A flit written at edge N appears on flit_out after edge N.
- flit_out, route_req, is_head and is_tail are combinational from FIFO/FSM state. They are valid within the same cycle, which suits the zero-delay downstream arbiter.
- Pop occurs at the edge where forward is high. credit_out is registered and asserts for exactly the cycle after each pop, including auto-pops.
- Simultaneous read and write with 0<count<DEPTH: count is unchanged and both pointers advance.
- Simultaneous read and write on an empty FIFO: only the write takes effect.
- Deasserting rst mid-packet gives a clean IDLE state with no credit pulse. Upstream must also be reset.

## Structure
- Shared package router_pkg holds:
  - Direction index constants (N=0, S=1, W=2, E=3, L=4) and the 5-bit one-hot port type.
  - Flit field positions and the flit_t struct.
  - The XY route function, shared with the other input units.
- Sub-module router_fifo: a generic DEPTH×FLIT_W synchronous FIFO with full, empty, count, push and pop. It is reused for output staging.
- The input unit adds the FSM, route_q, the credit register and the error flags.

## Test plan
- LOCAL=(1,1). Head+tail flit with dest (3,1) written at cycle 0 → cycle 1: valid_out=1, route_req=5'b01000. forward in cycle 1 → credit_out=1 in cycle 2, and valid_out returns to 0.
- 4-flit packet with dest (1,0) → route_req=5'b00001 on all four flits. Insert a 2-cycle bubble between flits 2 and 3: route_req=0 during the bubble, then 5'b00001 resumes. After the tail, state is IDLE.
- DEPTH=4. Five writes with no forward → count saturates at 4, overflow=1 after the fifth edge, and flits 1–4 are intact.
- Full FIFO with one forward and one write in the same cycle → the write is dropped and overflow=1. Four credits total are returned after draining.
- Body flit arrives first (head=0) → protocol_err=1, the flit is popped without forward, credit_out pulses once, and route_req stays 0.
- rst asserted mid-packet with 3 flits queued → outputs go to 0 immediately. After release, a new head with dest (1,1) → route_req=5'b10000.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: direction encoding, flit layout and XY routing.
package router_pkg;

  // Direction indices into the one-hot port vector
  localparam int unsigned DIR_N    = 0;
  localparam int unsigned DIR_S    = 1;
  localparam int unsigned DIR_W    = 2;
  localparam int unsigned DIR_E    = 3;
  localparam int unsigned DIR_L    = 4;
  localparam int unsigned NUM_DIRS = 5;

  typedef logic [NUM_DIRS-1:0] port_t;

  localparam port_t PORT_NONE = 5'b00000;
  localparam port_t PORT_N    = 5'b00001;
  localparam port_t PORT_S    = 5'b00010;
  localparam port_t PORT_W    = 5'b00100;
  localparam port_t PORT_E    = 5'b01000;
  localparam port_t PORT_L    = 5'b10000;

  localparam int unsigned COORD_W = 3;
  typedef logic [COORD_W-1:0] coord_t;

  // Field positions as offsets from the flit width: bit index = FLIT_W - OFS
  localparam int unsigned HEAD_OFS = 1;
  localparam int unsigned TAIL_OFS = 2;
  localparam int unsigned DX_OFS   = 3;
  localparam int unsigned DY_OFS   = 6;

  localparam int unsigned FLIT_W_DEF = 34;
  localparam int unsigned PAYLOAD_W  = FLIT_W_DEF - 2 - 2 * COORD_W;

  typedef struct packed {
    logic                 head;
    logic                 tail;
    coord_t               dest_x;
    coord_t               dest_y;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally
  function automatic port_t xy_route(input coord_t dest_x, input coord_t dest_y,
                                     input coord_t local_x, input coord_t local_y);
    port_t r;
    r = PORT_NONE;
    if (dest_x > local_x)      r = PORT_E;
    else if (dest_x < local_x) r = PORT_W;
    else if (dest_y < local_y) r = PORT_N;
    else if (dest_y > local_y) r = PORT_S;
    else                       r = PORT_L;
    return r;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Generic synchronous circular-buffer FIFO; push when full and pop when empty are ignored.
module router_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because empty gates their use
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_input_unit.sv
// Router input port: flit buffering, XY route computation held per packet, credit return.
module router_input_unit
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W  = 34,
  parameter int unsigned DEPTH   = 4,
  parameter coord_t      LOCAL_X = 3'd0,
  parameter coord_t      LOCAL_Y = 3'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              credit_out,
  input  logic              forward,
  output logic [FLIT_W-1:0] flit_out,
  output logic              valid_out,
  output port_t             route_req,
  output logic              is_head,
  output logic              is_tail,
  output logic              overflow,
  output logic              protocol_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  logic [FLIT_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              err_set;
  logic [0:0]        state;
  logic [0:0]        state_next;
  port_t             route_q;
  port_t             route_q_next;
  port_t             head_route;
  coord_t            dest_x;
  coord_t            dest_y;
  logic              head_bit;
  logic              tail_bit;

  // Incoming flits are dropped (and flagged) whenever the buffer is already full
  assign push = data_in_valid && !fifo_full;

  router_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head-of-queue view, forced to zero when nothing is buffered
  assign valid_out  = (fifo_count != '0);
  assign flit_out   = fifo_empty ? '0 : fifo_dout;
  assign head_bit   = flit_out[FLIT_W-HEAD_OFS];
  assign tail_bit   = flit_out[FLIT_W-TAIL_OFS];
  assign is_head    = head_bit;
  assign is_tail    = tail_bit;
  assign dest_x     = flit_out[FLIT_W-DX_OFS -: COORD_W];
  assign dest_y     = flit_out[FLIT_W-DY_OFS -: COORD_W];
  assign head_route = xy_route(dest_x, dest_y, LOCAL_X, LOCAL_Y);

  // Packet state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      route_q <= PORT_NONE;
    end else begin
      state   <= state_next;
      route_q <= route_q_next;
    end
  end

  // Next-state, pop decision and route request for the flit at the head of the queue
  always_comb begin
    state_next   = state;
    route_q_next = route_q;
    pop          = 1'b0;
    err_set      = 1'b0;
    route_req    = PORT_NONE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_bit) begin
            route_req = head_route;
            if (forward) begin
              pop = 1'b1;
              if (!tail_bit) begin
                state_next   = BODY;
                route_q_next = head_route;
              end
            end
          end else begin
            // Stray body flit with no packet open: discard it and return its credit
            pop     = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      BODY: begin
        if (!fifo_empty) begin
          route_req = route_q;
          if (head_bit) err_set = 1'b1;
          if (forward) begin
            pop = 1'b1;
            if (tail_bit) begin
              state_next   = IDLE;
              route_q_next = PORT_NONE;
            end
          end
        end
      end
      default: begin
        state_next   = IDLE;
        route_q_next = PORT_NONE;
      end
    endcase
  end

  // Credit pulse follows each pop by one cycle; error flags are sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_out   <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      credit_out <= pop;
      if (data_in_valid && fifo_full) overflow     <= 1'b1;
      if (err_set)                    protocol_err <= 1'b1;
    end
  end

endmodule
